// File: rtl/slow_tick_timer_if.sv
// Control/status bundle for slow_tick_timer: start/stop/load requests in, count and pulses out.
interface slow_tick_timer_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic             start;
  logic             stop;
  logic             auto_reload;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] count;
  logic             tick;
  logic             expired;
  logic             busy;

  modport master (
    output start, stop, auto_reload, load_value,
    input  count, tick, expired, busy
  );

  modport slave (
    input  start, stop, auto_reload, load_value,
    output count, tick, expired, busy
  );
endinterface

// File: rtl/slow_tick_timer.sv
// Countdown timer clocked by rising edges of slow_clk seen in the clk domain.
// Define SLOW_TICK_SYNC_EN to add a 2-flop synchronizer on slow_clk (tick latency 3 instead of 1).
module slow_tick_timer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             slow_clk,
  slow_tick_timer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             ar_q, ar_d;
  logic             expired_q, expired_d;
  logic             s0_q;
  logic             tick_q;
  logic             slow_in;

`ifdef SLOW_TICK_SYNC_EN
  logic sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= slow_clk;
      sync2_q <= sync1_q;
    end
  end

  assign slow_in = sync2_q;
`else
  // Only valid when slow_clk is derived from clk.
  assign slow_in = slow_clk;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q   <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      s0_q   <= slow_in;
      tick_q <= slow_in & ~s0_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      count_q   <= '0;
      reload_q  <= '0;
      ar_q      <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      reload_q  <= reload_d;
      ar_q      <= ar_d;
      expired_q <= expired_d;
    end
  end

  // Priority: start > stop > tick.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    reload_d  = reload_q;
    ar_d      = ar_q;
    expired_d = 1'b0;

    if (bus.start) begin
      reload_d = bus.load_value;
      ar_d     = bus.auto_reload;
      if (bus.load_value != '0) begin
        count_d = bus.load_value;
        state_d = StRun;
      end else begin
        // Zero-length request expires immediately without ever running.
        count_d   = '0;
        expired_d = 1'b1;
        state_d   = StIdle;
      end
    end else begin
      unique case (state_q)
        StIdle: ;
        StRun: begin
          if (bus.stop) begin
            state_d = StPause;
          end else if (tick_q) begin
            if (count_q == WIDTH'(1)) begin
              expired_d = 1'b1;
              if (ar_q) begin
                count_d = reload_q;
              end else begin
                count_d = '0;
                state_d = StIdle;
              end
            end else if (count_q != '0) begin
              count_d = count_q - WIDTH'(1);
            end
          end
        end
        StPause: begin
          if (bus.stop) begin
            state_d = StRun;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign bus.count   = count_q;
  assign bus.tick    = tick_q;
  assign bus.expired = expired_q;
  assign bus.busy    = (state_q != StIdle);

endmodule

// File: tb/tb_slow_tick_timer.sv
// Self-checking bench for slow_tick_timer: directed scenarios plus random traffic vs a reference model.
module tb_slow_tick_timer;

`ifdef SLOW_TICK_SYNC_EN
  localparam int Lat = 3;
`else
  localparam int Lat = 1;
`endif

  logic clk;
  logic rst_n;
  logic slow_clk;
  bit   slow_v;

  slow_tick_timer_if #(.WIDTH(16)) ifc ();

  slow_tick_timer #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .slow_clk (slow_clk),
    .bus      (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: "active" timer with remaining ticks, paused flag, pending tick pulse.
  bit m_act, m_pause, m_exp, m_tick, m_ar;
  int m_cnt, m_rel;
  bit hist [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_act = 0; m_pause = 0; m_exp = 0; m_tick = 0; m_ar = 0;
    m_cnt = 0; m_rel = 0;
    for (int i = 0; i < 4; i++) hist[i] = 0;
  endtask

  task automatic model_edge(input bit st, input bit sp, input bit ar, input int ld, input bit sl);
    m_exp = 0;
    if (st) begin
      m_rel = ld;
      m_ar  = ar;
      m_pause = 0;
      if (ld != 0) begin
        m_cnt = ld; m_act = 1;
      end else begin
        m_cnt = 0; m_act = 0; m_exp = 1;
      end
    end else if (m_act && !m_pause) begin
      if (sp) m_pause = 1;
      else if (m_tick) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          m_exp = 1;
          if (m_ar) m_cnt = m_rel;
          else m_act = 0;
        end
      end
    end else if (m_act && m_pause && sp) begin
      m_pause = 0;
    end
    for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = sl;
    m_tick = hist[Lat-1] & ~hist[Lat];
  endtask

  // Called at a negedge: drive inputs, let one posedge happen, check at the next negedge.
  task automatic step(input bit st, input bit sp, input bit ar, input logic [15:0] ld);
    ifc.start       = st;
    ifc.stop        = sp;
    ifc.auto_reload = ar;
    ifc.load_value  = ld;
    slow_clk        = slow_v;
    @(posedge clk);
    model_edge(st, sp, ar, int'(ld), slow_v);
    @(negedge clk);
    check("count",   32'(ifc.count), 32'(m_cnt));
    check("busy",    32'(ifc.busy),  32'(m_act));
    check("expired", 32'(ifc.expired), 32'(m_exp));
    check("tick",    32'(ifc.tick),  32'(m_tick));
    ifc.start = 1'b0;
    ifc.stop  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 16'd0);
  endtask

  task automatic pulse_tick();
    slow_v = 1; idle(2);
    slow_v = 0; idle(2);
  endtask

  // Advance until the model says a tick is visible now (bounded).
  task automatic wait_tick();
    slow_v = 1;
    for (int i = 0; i < 8 && !m_tick; i++) idle(1);
    check("wait_tick_bound", 32'(m_tick), 32'd1);
  endtask

  initial begin
    int t1, t2, nt;
    rst_n = 1'b0;
    slow_v = 0; slow_clk = 1'b0;
    ifc.start = 0; ifc.stop = 0; ifc.auto_reload = 0; ifc.load_value = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_count", 32'(ifc.count), 32'd0);
    check("rst_busy",  32'(ifc.busy),  32'd0);
    rst_n = 1'b1;
    idle(3);

    // One-shot 5
    step(1, 0, 0, 16'd5);
    for (int i = 0; i < 7; i++) pulse_tick();

    // Periodic 3
    step(1, 0, 1, 16'd3);
    for (int i = 0; i < 7; i++) pulse_tick();

    // Pause at 4, hold over 3 ticks, resume, restart from pause
    step(1, 0, 0, 16'd6);
    pulse_tick(); pulse_tick();
    check("pause_at4", 32'(ifc.count), 32'd4);
    step(0, 1, 0, 16'd0);
    for (int i = 0; i < 3; i++) pulse_tick();
    check("pause_hold", 32'(ifc.count), 32'd4);
    step(0, 1, 0, 16'd0);
    pulse_tick();
    check("resume_dec", 32'(ifc.count), 32'd3);
    step(0, 1, 0, 16'd0);
    step(1, 0, 0, 16'd9);
    check("restart_pause", 32'(ifc.count), 32'd9);
    check("restart_busy",  32'(ifc.busy),  32'd1);

    // Corners: zero load, start+stop, stop coincident with tick
    slow_v = 0; idle(4);
    step(1, 0, 0, 16'd0);
    idle(2);
    step(1, 0, 0, 16'd0);
    step(1, 0, 0, 16'd5);
    step(1, 1, 0, 16'd6);
    check("start_stop_cnt", 32'(ifc.count), 32'd6);
    wait_tick();
    step(0, 1, 0, 16'd0);
    check("stop_tick_drop", 32'(ifc.count), 32'd6);
    slow_v = 0; idle(3);
    step(0, 1, 0, 16'd0);

    // Reset mid-run with count 7
    step(1, 0, 0, 16'd7);
    #2 rst_n = 1'b0;
    #1;
    check("arst_count",   32'(ifc.count),   32'd0);
    check("arst_busy",    32'(ifc.busy),    32'd0);
    check("arst_expired", 32'(ifc.expired), 32'd0);
    check("arst_tick",    32'(ifc.tick),    32'd0);
    model_reset();
    slow_v = 0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Tick spacing/latency with the real slow_clk half period
    t1 = -1; t2 = -1; nt = 0;
    step(1, 0, 1, 16'd2);
    for (int c = 0; c < 3 * 3124; c++) begin
      if (c > 0 && (c % 1562) == 0) slow_v = ~slow_v;
      step(0, 0, 0, 16'd0);
      if (ifc.tick === 1'b1) begin
        if (nt == 0) t1 = c; else if (nt == 1) t2 = c;
        nt++;
      end
    end
    check("tick_seen",    32'(nt >= 2), 32'd1);
    check("tick_latency", 32'(t1 - 1562), 32'(Lat - 1));
    check("tick_spacing", 32'(t2 - t1), 32'd3124);

    // Random traffic
    slow_v = 0;
    for (int c = 0; c < 3000; c++) begin
      bit st, sp, ar;
      logic [15:0] ld;
      if ($urandom_range(2, 0) == 0) slow_v = ~slow_v;
      st = ($urandom_range(39, 0) == 0);
      sp = ($urandom_range(14, 0) == 0);
      ar = $urandom_range(1, 0) == 1;
      ld = 16'($urandom_range(6, 0));
      step(st, sp, ar, ld);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
